// File: rtl/voice_mixer.sv
// voice_mixer: once per audio period, snapshots the oscillator samples, sums the
// enabled voices one per cycle, normalises by floor(log2(active voices)), saturates
// and offers the result to i2s_tx over a valid/ready handshake.
// Optional soft-knee clipping stage: define VOICE_MIXER_SOFT_CLIP_EN.
module voice_mixer #(
   parameter int unsigned NUM_OSCILLATORS = 4,
   parameter int unsigned SAMPLE_WIDTH    = 16,
   parameter int unsigned CLK_PER_SAMPLE  = 2268,
   parameter int unsigned OVR_WIDTH       = 8
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [NUM_OSCILLATORS-1:0] is_on_in,
   input  logic [SAMPLE_WIDTH-1:0]    osc_data_in [NUM_OSCILLATORS],
   output logic [SAMPLE_WIDTH-1:0]    stream_out,
   output logic                       stream_valid_out,
   input  logic                       stream_ready_in,
   output logic [OVR_WIDTH-1:0]       overrun_count_out
);

   // Wide enough that summing every voice at full scale never wraps.
   localparam int unsigned AccW = SAMPLE_WIDTH + $clog2(NUM_OSCILLATORS) + 1;
   localparam int unsigned CntW = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
   localparam int unsigned IdxW = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
   localparam int unsigned ActW = $clog2(NUM_OSCILLATORS + 1);
   localparam int unsigned ShW  = (ActW > 1) ? $clog2(ActW) : 1;

   localparam logic [CntW-1:0] LastCnt = CntW'(CLK_PER_SAMPLE - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OSCILLATORS - 1);
   localparam logic signed [AccW-1:0] SatMax =
      {{(AccW - SAMPLE_WIDTH + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
   localparam logic signed [AccW-1:0] SatMin =
      {{(AccW - SAMPLE_WIDTH + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};
`ifdef VOICE_MIXER_SOFT_CLIP_EN
   // Knee at three quarters of full scale, minus one.
   localparam logic signed [AccW-1:0] SoftT = AccW'(3 * (2 ** (SAMPLE_WIDTH - 3)) - 1);
`endif

   typedef enum logic [2:0] {
      StIdle,
      StAccum,
      StNorm,
`ifdef VOICE_MIXER_SOFT_CLIP_EN
      StClip,
`endif
      StHold
   } state_e;

   state_e                     state_q, state_d;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic [NUM_OSCILLATORS-1:0] snap_on_q, snap_on_d;
   logic [SAMPLE_WIDTH-1:0]    snap_data_q [NUM_OSCILLATORS];
   logic [SAMPLE_WIDTH-1:0]    snap_data_d [NUM_OSCILLATORS];
   logic signed [AccW-1:0]     acc_q, acc_d;
   logic [ActW-1:0]            act_q, act_d;
   logic [IdxW-1:0]            idx_q, idx_d;
   logic [SAMPLE_WIDTH-1:0]    stream_q, stream_d;
   logic                       valid_q, valid_d;
   logic [OVR_WIDTH-1:0]       ovr_q, ovr_d;
`ifdef VOICE_MIXER_SOFT_CLIP_EN
   logic signed [AccW-1:0]     shift_q, shift_d;
`endif

   logic                       tick;
   logic [SAMPLE_WIDTH-1:0]    cur_sample;
   logic signed [AccW-1:0]     sample_ext;
   logic [ShW-1:0]             shamt;
   logic signed [AccW-1:0]     shifted;

   function automatic logic [SAMPLE_WIDTH-1:0] saturate(input logic signed [AccW-1:0] x);
      if (x > SatMax) return SatMax[SAMPLE_WIDTH-1:0];
      if (x < SatMin) return SatMin[SAMPLE_WIDTH-1:0];
      return x[SAMPLE_WIDTH-1:0];
   endfunction

`ifdef VOICE_MIXER_SOFT_CLIP_EN
   // Above the knee the excess magnitude is compressed 4:1, sign preserved.
   function automatic logic signed [AccW-1:0] soft_clip(input logic signed [AccW-1:0] x);
      logic signed [AccW-1:0] mag;
      mag = x[AccW-1] ? -x : x;
      if (mag > SoftT) mag = SoftT + ((mag - SoftT) >>> 2);
      return x[AccW-1] ? -mag : mag;
   endfunction
`endif

   assign tick       = (cnt_q == LastCnt);
   assign cur_sample = snap_data_q[idx_q];
   assign sample_ext = {{(AccW - SAMPLE_WIDTH){cur_sample[SAMPLE_WIDTH-1]}}, cur_sample};
   assign shifted    = acc_q >>> shamt;

   // Normalising shift: index of the highest set bit of the active count (0 for 0 or 1).
   always_comb begin
      shamt = '0;
      for (int unsigned i = 1; i < ActW; i++) begin
         if (act_q[i]) shamt = ShW'(i);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (tick) state_d = StAccum;
         StAccum: if (idx_q == LastIdx) state_d = StNorm;
`ifdef VOICE_MIXER_SOFT_CLIP_EN
         StNorm:  state_d = StClip;
         StClip:  state_d = StHold;
`else
         StNorm:  state_d = StHold;
`endif
         StHold:  if (valid_q && stream_ready_in) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath and output next-state, decoded from the FSM state.
   always_comb begin
      cnt_d       = tick ? '0 : cnt_q + CntW'(1);
      snap_on_d   = snap_on_q;
      snap_data_d = snap_data_q;
      acc_d       = acc_q;
      act_d       = act_q;
      idx_d       = idx_q;
      stream_d    = stream_q;
      valid_d     = valid_q;
      ovr_d       = ovr_q;
`ifdef VOICE_MIXER_SOFT_CLIP_EN
      shift_d     = shift_q;
`endif
      // A tick outside IDLE (including on a transfer cycle) is a dropped period.
      if (tick && (state_q != StIdle) && (ovr_q != '1)) ovr_d = ovr_q + OVR_WIDTH'(1);
      unique case (state_q)
         StIdle: begin
            if (tick) begin
               snap_on_d   = is_on_in;
               snap_data_d = osc_data_in;
               acc_d       = '0;
               act_d       = '0;
               idx_d       = '0;
            end
         end
         StAccum: begin
            if (snap_on_q[idx_q]) begin
               acc_d = acc_q + sample_ext;
               act_d = act_q + ActW'(1);
            end
            idx_d = idx_q + IdxW'(1);
         end
         StNorm: begin
`ifdef VOICE_MIXER_SOFT_CLIP_EN
            shift_d  = shifted;
`else
            stream_d = saturate(shifted);
            valid_d  = 1'b1;
`endif
         end
`ifdef VOICE_MIXER_SOFT_CLIP_EN
         StClip: begin
            stream_d = saturate(soft_clip(shift_q));
            valid_d  = 1'b1;
         end
`endif
         StHold: begin
            if (stream_ready_in) valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath registers; reset clears everything so no partial sample survives.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q       <= '0;
         snap_on_q   <= '0;
         snap_data_q <= '{default: '0};
         acc_q       <= '0;
         act_q       <= '0;
         idx_q       <= '0;
         stream_q    <= '0;
         valid_q     <= 1'b0;
         ovr_q       <= '0;
`ifdef VOICE_MIXER_SOFT_CLIP_EN
         shift_q     <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         snap_on_q   <= snap_on_d;
         snap_data_q <= snap_data_d;
         acc_q       <= acc_d;
         act_q       <= act_d;
         idx_q       <= idx_d;
         stream_q    <= stream_d;
         valid_q     <= valid_d;
         ovr_q       <= ovr_d;
`ifdef VOICE_MIXER_SOFT_CLIP_EN
         shift_q     <= shift_d;
`endif
      end
   end

   assign stream_out        = stream_q;
   assign stream_valid_out  = valid_q;
   assign overrun_count_out = ovr_q;

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Downstream of wave_loader. Takes the per-oscillator samples (osc_data_out) and on/off flags. Produces one mixed, normalised, saturated signed sample per audio period.
- The mixed sample goes to i2s_tx over a valid/ready handshake.
- It replaces the temporary "stream = osc_samples[0]" path and the mixing role of midi_coordinator.

Parameters:
- NUM_OSCILLATORS, 4, number of voices mixed (1..16).
- SAMPLE_WIDTH, 16, width of the signed two's-complement sample.
- CLK_PER_SAMPLE, 2268, clk_in cycles per audio sample (100 MHz / 44.1 kHz, rounded).
- OVR_WIDTH, 8, width of the overrun counter.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  asynchronous, active-high reset.
- is_on_in  input  NUM_OSCILLATORS  per-voice enable.
- osc_data_in  input  [SAMPLE_WIDTH-1:0] x NUM_OSCILLATORS (unpacked)  per-voice signed sample from wave_loader.
- stream_out  output  SAMPLE_WIDTH  mixed signed sample.
- stream_valid_out  output  1  stream_out holds a new sample.
- stream_ready_in  input  1  consumer accepts stream_out.
- overrun_count_out  output  OVR_WIDTH  saturating count of dropped sample periods.

Behaviour:
- Reset (async assert; released synchronously to clk_in): stream_out=0, stream_valid_out=0, overrun_count_out=0, tick counter=0, state=IDLE. Accumulator and snapshot registers are cleared.
- Reset mid-operation aborts any in-progress mix; no partial sample is ever presented.
- Tick counter:
  - Counts 0..CLK_PER_SAMPLE-1 and wraps.
  - tick=1 when the counter equals CLK_PER_SAMPLE-1.
  - The first tick is at cycle CLK_PER_SAMPLE-1 after reset release.
- States: IDLE, ACCUM, NORM, [CLIP], HOLD.
- IDLE:
  - On tick, snapshot all osc_data_in and is_on_in into registers.
  - Clear the accumulator and active count, set voice index=0, go to ACCUM.
- ACCUM:
  - One voice per cycle, index 0..NUM_OSCILLATORS-1.
  - If the snapshotted is_on[i]=1: accumulator += sign-extended sample[i] and active count += 1.
  - After the last index, go to NORM.
  - Accumulator width is SAMPLE_WIDTH+$clog2(NUM_OSCILLATORS)+1, so it never wraps.
- NORM:
  - Shift amount s = floor(log2(active)), with s=0 for 0 or 1 active voices (2,3→1; 4..7→2; 8..15→3; 16→4).
  - Arithmetic right shift by s (rounds toward -inf).
  - Hard-saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - Then go to HOLD, or to CLIP when the optional feature is enabled.
- HOLD:
  - On entry, register stream_out and set stream_valid_out=1.
  - stream_out stays stable while valid=1 and ready=0.
  - On the cycle valid&ready=1 the transfer occurs: stream_valid_out=0 next cycle, go to IDLE.
- Latency:
  - stream_valid_out rises at tick+NUM_OSCILLATORS+2 cycles.
  - With SOFT_CLIP_EN, at tick+NUM_OSCILLATORS+3 cycles.
- Zero active voices: a valid sample of 0 is still produced every period.
- Overrun:
  - A tick arriving in any state other than IDLE is dropped and the in-progress sample is kept.
  - overrun_count_out += 1, saturating at all-ones.
  - A tick coinciding with a transfer (valid&ready) is also dropped, because the state is still HOLD.
- stream_ready_in is never required to be high before valid.

Optional Feature:
- Macro: VOICE_MIXER_SOFT_CLIP_EN.
- Enabled: adds a CLIP state after NORM, which applies to the shifted, pre-saturation value x:
  - T = 3*2^(SAMPLE_WIDTH-1)/4 - 1 (24575 for 16 bits).
  - If |x| > T: y = sign(x)*(T + ((|x|-T)>>2)); otherwise y = x.
  - y is then hard-saturated. This adds one cycle of latency.
- Disabled: NORM goes directly to HOLD with hard saturation only.

Test Plan (NUM_OSCILLATORS=4, CLK_PER_SAMPLE=16, SAMPLE_WIDTH=16):
- Voice 0 only on, data 0x1234, ready=1 → stream_out=0x1234, valid high 6 cycles after tick for exactly 1 cycle; repeats every 16 cycles; overrun_count_out=0.
- All 4 on, each 0x7FFF → 0x7FFF (sum 0x1FFFC, s=2). Voices 0,1 on with 0x8000 each → 0x8000.
- Voices 0–2 on, each 0x6000 → without the macro, 0x7FFF (36864 saturated); with VOICE_MIXER_SOFT_CLIP_EN, 0x6BFF (27647), valid at tick+7.
- Voices 0–2 on, each 0x8000 → 0x8000 (-49152 saturated). No voices on → 0x0000, still valid each period.
- ready held low for 40 cycles → stream_out stable and valid high throughout; overrun_count_out=2; after ready=1 the first sample transfers, and the next sample comes from the following tick.
- Assert rst_in asynchronously during ACCUM → outputs 0 immediately with no clock edge; after release, the first valid comes at 15+6 cycles.
